// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch slice.
// Holds the fetch-queue entry layout and the word-alignment helper.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Circular FIFO between fetch and decode, with synchronous flush.
// The head reads as zero whenever the queue is empty.
module if_fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  fq_entry_t   push_data,
    input  logic        pop,
    output fq_entry_t   head,
    output logic [PW:0] count,
    output logic        full,
    output logic        empty
);

    fq_entry_t     mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW:0]   count_r;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == (PW+1)'(0));
    assign count     = count_r;
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, pointers and occupancy; flush only rewinds the bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head view, masked to zero while the queue holds nothing.
    always_comb begin
        head = '0;
        if (empty) begin
            head = '0;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single in-flight
// memory requests and queues returned words with prediction metadata.
module if_fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] bp_pc,
    input  logic            bp_hit,
    input  logic            bp_taken,
    input  logic [XLEN-1:0] bp_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken,
    output logic [XLEN-1:0] id_pred_target
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] pc_r;
    logic            outstanding_r;
    logic            discard_r;
    logic [XLEN-1:0] pend_pc_r;
    logic            pend_taken_r;
    logic [XLEN-1:0] pend_target_r;

    logic [XLEN-1:0] npc_s;
    logic            pred_taken_s;
    logic            req_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   count_s;
    logic            full_s;
    logic            empty_s;
    fq_entry_t       push_data_s;
    fq_entry_t       head_s;

    assign pred_taken_s = bp_hit && bp_taken;
    assign bp_pc        = pc_r;
    assign imem_addr    = pc_r;
    assign imem_req     = req_s;

    // Next-PC select and request gating; only one request may be in flight.
    always_comb begin
        npc_s = word_align(pc_r + XLEN'(INSTR_BYTES));
        req_s = 1'b0;
        if (pred_taken_s) begin
            npc_s = word_align(bp_target);
        end else begin
            npc_s = word_align(pc_r + XLEN'(INSTR_BYTES));
        end
        if (rst && !outstanding_r && (count_s < CW'(FQ_DEPTH)) && !ex_redirect) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // A response is only kept when it belongs to the live fetch stream.
    assign push_s      = imem_rvalid && outstanding_r && !discard_r && !ex_redirect;
    assign pop_s       = !empty_s && id_ready;
    assign push_data_s = '{instr:       imem_rdata,
                           pc:          pend_pc_r,
                           pred_taken:  pend_taken_r,
                           pred_target: pend_target_r};

    // PC, in-flight tracking and pending metadata; redirect has top priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r          <= RESET_PC;
            outstanding_r <= 1'b0;
            discard_r     <= 1'b0;
            pend_pc_r     <= '0;
            pend_taken_r  <= 1'b0;
            pend_target_r <= '0;
        end else if (ex_redirect) begin
            pc_r <= word_align(ex_redirect_pc);
            if (outstanding_r && !imem_rvalid) begin
                discard_r <= 1'b1;
            end else if (outstanding_r) begin
                outstanding_r <= 1'b0;
                discard_r     <= 1'b0;
            end
        end else begin
            if (imem_rvalid && outstanding_r) begin
                outstanding_r <= 1'b0;
                discard_r     <= 1'b0;
            end
            if (req_s && imem_gnt) begin
                outstanding_r <= 1'b1;
                pc_r          <= npc_s;
                pend_pc_r     <= pc_r;
                pend_taken_r  <= pred_taken_s;
                pend_target_r <= npc_s;
            end
        end
    end

    if_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (ex_redirect),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign id_valid       = !empty_s;
    assign id_instr       = head_s.instr;
    assign id_pc          = head_s.pc;
    assign id_pred_taken  = head_s.pred_taken;
    assign id_pred_target = head_s.pred_target;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based reference of the
// fetch stream, with a memory model answering one request at a time.
module tb_if_fetch_unit;
    import core_pkg::*;

    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] bp_pc;
    logic        bp_hit;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;

    if_fetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .bp_pc          (bp_pc),
        .bp_hit         (bp_hit),
        .bp_taken       (bp_taken),
        .bp_target      (bp_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    // Reference state: the fetch stream as the rules describe it.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_disc;
    exp_t        m_q[$];
    exp_t        m_pend;
    bit          mem_pend;
    int          mem_delay;
    logic [31:0] grant_log[$];
    bit          f_redir;
    logic [31:0] f_redir_pc;
    int          n_checks;
    int          n_fail;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic run_cycle(input int p_redir, input int p_ready, input int p_gnt,
                             input int p_hit, input int max_lat);
        bit          exp_req;
        bit          grant;
        bit          hit_taken;
        logic [31:0] npc;
        exp_t        e;
        @(negedge clk);
        if (mem_pend) imem_rvalid = (mem_delay == 0);
        else          imem_rvalid = ($urandom_range(0, 15) == 0);
        imem_rdata = $urandom;
        imem_gnt   = ($urandom_range(0, 99) < p_gnt);
        bp_hit     = ($urandom_range(0, 99) < p_hit);
        bp_taken   = 1'($urandom_range(0, 1));
        bp_target  = $urandom;
        if (f_redir) begin
            ex_redirect    = 1'b1;
            ex_redirect_pc = f_redir_pc;
            f_redir        = 1'b0;
        end else begin
            ex_redirect    = ($urandom_range(0, 99) < p_redir);
            ex_redirect_pc = $urandom;
        end
        id_ready = ($urandom_range(0, 99) < p_ready);
        #1;
        exp_req = !m_out && (m_q.size() < FQ_DEPTH) && !ex_redirect;
        check_val("bp_pc", bp_pc, m_pc);
        check_val("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_val("imem_addr", imem_addr, m_pc);
        check_val("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("id_instr", id_instr, m_q[0].instr);
            check_val("id_pc", id_pc, m_q[0].pc);
            check_val("id_pred_taken", 32'(id_pred_taken), 32'(m_q[0].taken));
            check_val("id_pred_target", id_pred_target, m_q[0].target);
        end
        hit_taken = bp_hit && bp_taken;
        npc       = hit_taken ? bp_target : m_pc + 32'd4;
        npc       = npc & 32'hFFFF_FFFC;
        grant     = exp_req && imem_gnt;
        if (ex_redirect) begin
            m_q.delete();
            m_pc = ex_redirect_pc & 32'hFFFF_FFFC;
            if (m_out) begin
                if (imem_rvalid) begin
                    m_out  = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_disc = 1'b1;
                end
            end
        end else begin
            if (m_q.size() != 0 && id_ready) void'(m_q.pop_front());
            if (imem_rvalid && m_out) begin
                if (!m_disc) begin
                    e       = m_pend;
                    e.instr = imem_rdata;
                    m_q.push_back(e);
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end
            if (grant) begin
                m_pend = '{instr: 32'h0, pc: m_pc, taken: hit_taken, target: npc};
                grant_log.push_back(m_pc);
                m_pc  = npc;
                m_out = 1'b1;
            end
        end
        if (mem_pend && imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend)           mem_delay--;
        if (grant) begin
            mem_pend  = 1'b1;
            mem_delay = $urandom_range(0, max_lat - 1);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst         = 1'b0;
        ex_redirect = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        id_ready    = 1'b0;
        bp_hit      = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check_val("rst_imem_req", 32'(imem_req), 32'h0);
        check_val("rst_id_valid", 32'(id_valid), 32'h0);
        check_val("rst_id_instr", id_instr, 32'h0);
        check_val("rst_id_pc", id_pc, 32'h0);
        check_val("rst_id_pred_taken", 32'(id_pred_taken), 32'h0);
        check_val("rst_id_pred_target", id_pred_target, 32'h0);
        check_val("rst_bp_pc", bp_pc, RST_PC);
        m_pc     = RST_PC;
        m_out    = 1'b0;
        m_disc   = 1'b0;
        mem_pend = 1'b0;
        m_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int i;
        n_checks       = 0;
        n_fail         = 0;
        f_redir        = 1'b0;
        f_redir_pc     = 32'h0;
        rst            = 1'b0;
        bp_taken       = 1'b0;
        bp_target      = 32'h0;
        imem_rdata     = 32'h0;
        ex_redirect_pc = 32'h0;
        do_reset(2);

        // Sequential fetch from reset with an always-ready memory and decode.
        grant_log.delete();
        repeat (12) run_cycle(0, 100, 100, 0, 1);
        check_val("seq_grants", 32'(grant_log.size() >= 3), 32'h1);
        check_val("seq_addr0", grant_log[0], 32'h0000_0000);
        check_val("seq_addr1", grant_log[1], 32'h0000_0004);
        check_val("seq_addr2", grant_log[2], 32'h0000_0008);

        // Mixed traffic, predictions and occasional redirects.
        repeat (400) run_cycle(5, 70, 60, 50, 3);

        // Decode stall fills the queue, then drains in order.
        repeat (8)  run_cycle(0, 0, 100, 30, 1);
        repeat (12) run_cycle(0, 100, 100, 30, 1);

        // Redirect to an unaligned target while a request is still in flight.
        i = 0;
        while (i < 200 && !(m_out && mem_delay > 0)) begin
            run_cycle(0, 100, 100, 0, 4);
            i++;
        end
        check_val("redir_setup", 32'(m_out && mem_delay > 0), 32'h1);
        f_redir    = 1'b1;
        f_redir_pc = 32'h0000_0203;
        run_cycle(0, 100, 0, 0, 4);
        grant_log.delete();
        i = 0;
        while (i < 40 && grant_log.size() == 0) begin
            run_cycle(0, 100, 100, 0, 1);
            i++;
        end
        check_val("redir_grants", 32'(grant_log.size()), 32'h1);
        check_val("redir_addr", grant_log[0], 32'h0000_0200);
        repeat (6) run_cycle(0, 100, 100, 0, 1);

        // Redirect-heavy traffic with a mostly idle decode, then mid-run reset.
        repeat (300) run_cycle(20, 40, 80, 50, 2);
        do_reset(1);
        repeat (100) run_cycle(5, 70, 70, 50, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
